// File: rtl/a2d_scan_intf_if.sv
// a2d_scan_intf_if: host control, result and SPI signals of the A2D scan interface
interface a2d_scan_intf_if #(parameter int NUM_CH = 4);
  logic strt, cont, SS_n, SCLK, MOSI, MISO, sweep_done, busy;
  logic [12*NUM_CH-1:0] results;
  logic [NUM_CH-1:0] vld;
  modport master(input strt, cont, MISO, output SS_n, SCLK, MOSI, results, vld, sweep_done, busy);
  modport slave(output strt, cont, MISO, input SS_n, SCLK, MOSI, results, vld, sweep_done, busy);
endinterface

// File: rtl/a2d_scan_intf.sv
// a2d_scan_intf: pipelined multi-slot SPI scanner for an 8-channel 12-bit A2D
module a2d_scan_intf #(
  parameter int NUM_CH = 4,
  parameter logic [23:0] CH_MAP = 24'hFAC688,
  parameter int SCLK_DIV = 32,
  parameter int GAP_CYC = 8
) (
  input logic clk,
  input logic rst_n,
  a2d_scan_intf_if.master bus
);
  localparam int H = SCLK_DIV / 2;
  localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(SCLK_DIV + GAP_CYC);
  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} state_t;
  state_t r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_bit;
  logic [SW-1:0] r_tx, r_rx;
  logic r_first, r_stop, r_done;
  logic [11:0] r_sh;
  logic [12*NUM_CH-1:0] r_res;
  logic [NUM_CH-1:0] r_vld;
  logic w_pend, w_end, w_wr;
  logic [2:0] w_ch;
  logic [15:0] w_word;
  always_comb begin
    w_pend = r_cnt == CW'(2*H-1);
    w_end = (r_state == SHIFT) ? (w_pend && r_bit == 4'd15) :
            (r_state == GAP) ? (r_cnt == CW'(GAP_CYC-1)) :
            (r_state == FRONT || r_state == BACK) && r_cnt == CW'(H-1);
    w_wr = r_state == BACK && w_end && !r_first;
    w_ch = 3'(CH_MAP >> (3 * int'(r_tx)));
    w_word = {2'b00, w_ch, 11'b0};
    w_nxt = r_state;
    case (r_state)
      IDLE: w_nxt = bus.strt ? FRONT : IDLE;
      FRONT: w_nxt = w_end ? SHIFT : FRONT;
      SHIFT: w_nxt = w_end ? BACK : SHIFT;
      BACK: w_nxt = w_end ? GAP : BACK;
      GAP: w_nxt = w_end ? (r_stop ? IDLE : FRONT) : GAP;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_tx <= '0;
      r_rx <= '0;
      r_first <= 1'b0;
      r_stop <= 1'b0;
      r_done <= 1'b0;
      r_sh <= '0;
      r_res <= '0;
      r_vld <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= (r_state == IDLE || w_end || (r_state == SHIFT && w_pend)) ? '0 : r_cnt + 1'b1;
      if (r_state == SHIFT && w_pend) r_bit <= r_bit + 1'b1;
      if (r_state == SHIFT && r_cnt == CW'(H-1)) r_sh <= {r_sh[10:0], bus.MISO};
      r_vld <= '0;
      for (int i = 0; i < NUM_CH; i++)
        if (w_wr && r_rx == SW'(i)) begin
          r_res[12*i +: 12] <= r_sh;
          r_vld[i] <= 1'b1;
        end
      r_done <= w_wr && r_rx == SW'(NUM_CH-1);
      // a sweep ends only after the last slot lands; cont is judged at that write
      if (r_state == BACK && w_end) begin
        r_rx <= r_tx;
        r_tx <= (r_tx == SW'(NUM_CH-1)) ? '0 : r_tx + 1'b1;
        r_first <= 1'b0;
        r_stop <= w_wr && r_rx == SW'(NUM_CH-1) && !bus.cont;
      end
      if (r_state == IDLE && bus.strt) begin
        r_tx <= '0;
        r_first <= 1'b1;
        r_stop <= 1'b0;
      end
    end
  end
  assign bus.SS_n = !(r_state == FRONT || r_state == SHIFT || r_state == BACK);
  assign bus.SCLK = !(r_state == SHIFT && r_cnt < CW'(H));
  assign bus.MOSI = r_state == SHIFT && w_word[4'd15 - r_bit];
  assign bus.results = r_res;
  assign bus.vld = r_vld;
  assign bus.sweep_done = r_done;
  assign bus.busy = r_state != IDLE;
endmodule

// File: tb/tb_a2d_scan_intf.sv
// tb_a2d_scan_intf: randomized scoreboard bench with a behavioural A2D model
module tb_a2d_scan_intf;
  localparam int N = 4, SD = 4, GC = 2, H = SD / 2;
  localparam logic [23:0] MAP = 24'hFAC43D;
  localparam int FP = 17 * SD + GC;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  a2d_scan_intf_if #(.NUM_CH(N)) bus();
  a2d_scan_intf #(.NUM_CH(N), .CH_MAP(MAP), .SCLK_DIV(SD), .GAP_CYC(GC)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {int slot; logic [11:0] v;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int addrq[$];
  int checks = 0, errors = 0;
  int frames = 0, dones = 0, busy_cnt = 0;
  int ss_run = 0, lo_run = 0, hi_run = 0, prev_ch = 0;
  logic [11:0] val[8];
  logic [15:0] mo_sh, mi_word;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask
  function automatic int chmap(int s);
    return int'((MAP >> (3 * s)) & 24'h7);
  endfunction
  task automatic push_sweep();
    for (int s = 0; s < N; s++) sbq.push_back('{s, val[chmap(s)]});
  endtask
  task automatic new_vals();
    for (int i = 0; i < 8; i++) val[i] = 12'($urandom);
  endtask
  task automatic start_sweep(bit c);
    bus.cont = c;
    for (int s = 0; s < N; s++) addrq.push_back(chmap(s));
    addrq.push_back(chmap(0));
    push_sweep();
    frames = 0;
    dones = 0;
    busy_cnt = 0;
    bus.strt = 1'b1;
    @(negedge clk);
    bus.strt = 1'b0;
  endtask
  task automatic wait_idle(int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", bus.busy, 0);
  endtask
  task automatic check_results();
    for (int s = 0; s < N; s++) chk($sformatf("result_slot%0d", s), bus.results[12*s +: 12], val[chmap(s)]);
  endtask
  // A2D: returns the conversion of the channel addressed in the previous frame
  always @(negedge bus.SS_n) begin
    mi_word = {4'($urandom), val[prev_ch]};
    mo_sh = '0;
  end
  always @(negedge bus.SCLK) if (!bus.SS_n) begin
    bus.MISO = mi_word[15];
    mi_word = mi_word << 1;
  end
  always @(posedge bus.SCLK) if (!bus.SS_n) mo_sh = {mo_sh[14:0], bus.MOSI};
  always @(posedge bus.SS_n) if (rst_n) begin
    frames++;
    prev_ch = int'(mo_sh[13:11]);
    if (addrq.size() == 0) begin
      errors++;
      $display("FAIL extra_frame actual addr %0d required none", mo_sh[13:11]);
    end else chk("frame_addr", 32'(mo_sh[13:11]), addrq.pop_front());
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      ss_run = 0;
      lo_run = 0;
      hi_run = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (|bus.vld) begin
        chk("vld_onehot", 32'($onehot(bus.vld)), 1);
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld actual %0h required none", bus.vld);
        end else begin
          e = sbq.pop_front();
          chk("vld_slot", 32'(bus.vld), 32'(1) << e.slot);
          chk("result", 32'(bus.results[12*e.slot +: 12]), 32'(e.v));
          chk("sweep_done", 32'(bus.sweep_done), 32'(e.slot == N-1));
        end
      end else if (bus.sweep_done) begin
        errors++;
        $display("FAIL sweep_done_alone actual 1 required 0");
      end
      if (bus.sweep_done) dones++;
      if (!bus.SS_n) ss_run++;
      else if (ss_run > 0) begin
        chk("frame_len", ss_run, 17 * SD);
        ss_run = 0;
      end
      if (!bus.SCLK) lo_run++;
      else if (lo_run > 0) begin
        chk("sclk_low", lo_run, H);
        lo_run = 0;
      end
      if (bus.SS_n) hi_run = 0;
      else if (bus.SCLK) hi_run++;
      else if (hi_run > 0) begin
        chk("sclk_high", hi_run, H);
        hi_run = 0;
      end
    end
  end
  initial begin
    int n;
    bus.strt = 1'b0;
    bus.cont = 1'b0;
    bus.MISO = 1'b0;
    new_vals();
    repeat (3) @(negedge clk);
    chk("rst_ss_n", bus.SS_n, 1);
    chk("rst_sclk", bus.SCLK, 1);
    chk("rst_mosi", bus.MOSI, 0);
    chk("rst_results", 32'(bus.results == '0), 1);
    chk("rst_vld", bus.vld, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    val[chmap(0)] = 12'hABC;
    start_sweep(1'b0);
    chk("busy_after_strt", bus.busy, 1);
    n = 0;
    while ((bus.SS_n || bus.SCLK) && n < 500) begin
      @(negedge clk);
      n++;
    end
    bus.strt = 1'b1;
    @(negedge clk);
    bus.strt = 1'b0;
    chk("busy_strt_in_shift", bus.busy, 1);
    wait_idle(2000);
    chk("oneshot_frames", frames, N + 1);
    chk("oneshot_dones", dones, 1);
    chk("oneshot_busy_len", busy_cnt, (N + 1) * FP);
    chk("oneshot_sb_empty", sbq.size() + addrq.size(), 0);
    check_results();
    new_vals();
    start_sweep(1'b1);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!bus.sweep_done && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("cont_done_timeout", bus.sweep_done, 1);
      new_vals();
      push_sweep();
      for (int s = 1; s <= N; s++) addrq.push_back(chmap(s % N));
      if (k == 1) bus.cont = 1'b0;
      @(negedge clk);
    end
    wait_idle(5000);
    chk("cont_frames", frames, 3 * N + 1);
    chk("cont_dones", dones, 3);
    chk("cont_busy_len", busy_cnt, (3 * N + 1) * FP);
    chk("cont_sb_empty", sbq.size() + addrq.size(), 0);
    check_results();
    new_vals();
    start_sweep(1'b0);
    n = 0;
    while (!(frames == 2 && !bus.SS_n && !bus.SCLK) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("frame3_reached", frames, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", bus.SS_n, 1);
    chk("midrst_sclk", bus.SCLK, 1);
    chk("midrst_results", 32'(bus.results == '0), 1);
    chk("midrst_busy", bus.busy, 0);
    sbq.delete();
    addrq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    new_vals();
    start_sweep(1'b0);
    wait_idle(2000);
    chk("post_rst_frames", frames, N + 1);
    chk("post_rst_sb_empty", sbq.size() + addrq.size(), 0);
    check_results();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/a2d_scan_intf.md
Name: a2d_scan_intf

Overview:
Parametrised successor to the fixed four-reading A2D interface used by the eBike top level. It drives the on-board 8-channel 12-bit SPI A2D (ADC128S-style), scanning a configurable list of NUM_CH slots, each mapped to a physical channel. Transfers are pipelined: each 16-bit frame sends the next channel address and returns the previous conversion. It supports one-shot and continuous sweep modes, with per-slot valid strobes and an end-of-sweep strobe.

Parameters:
NUM_CH, 4, number of scan slots (1..8)
CH_MAP, 24'hFAC688, 3-bit physical channel per slot; slot i = CH_MAP[3*i+2:3*i] (default slots 0..3 = ch 0,1,2,3)
SCLK_DIV, 32, clk cycles per SCLK period (even, >=4)
GAP_CYC, 8, clk cycles SS_n held high between frames (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
strt  in  1  start sweep (sampled only when idle)
cont  in  1  continuous mode when high at start or during a sweep
SS_n  out  1  A2D slave select, active low
SCLK  out  1  SPI clock, idles high
MOSI  out  1  serial data to A2D
MISO  in  1  serial data from A2D
results  out  12*NUM_CH  slot i result at [12*i+11:12*i]
vld  out  NUM_CH  one-cycle pulse per slot when its result updates
sweep_done  out  1  one-cycle pulse when last slot of a sweep is written
busy  out  1  high from accepted strt until return to IDLE

Behaviour:
- Reset, async and mid-operation included: state IDLE, SS_n=1, SCLK=1, MOSI=0, results=0, vld=0, sweep_done=0, busy=0, slot pointers 0. Any in-flight frame is abandoned with no partial result written.
- States: IDLE -> FRONT -> SHIFT -> BACK -> GAP -> (FRONT | IDLE).
- IDLE: strt=1 -> FRONT. The slot pointer tx_slot is 0, a "first frame" flag is set, and busy=1 on the next cycle. strt is ignored while busy.
- FRONT: SS_n=0, SCLK=1 for SCLK_DIV/2 cycles.
- SHIFT: 16 SCLK periods. In each period SCLK is low for SCLK_DIV/2 cycles, then high for SCLK_DIV/2.
  - MOSI changes on the cycle SCLK falls. The frame word is {2'b00, CH_MAP[tx_slot], 11'b0}, sent MSB first.
  - MISO is sampled into a 16-bit shift register on the cycle SCLK rises.
- BACK: SCLK=1 and SS_n=0 for SCLK_DIV/2 cycles, then SS_n=1.
  - On the last BACK cycle, if the first-frame flag is clear: results[rx_slot] <= shreg[11:0] (upper 4 bits ignored) and vld[rx_slot] pulses.
  - rx_slot is the tx_slot of the previous frame. The first frame of every sweep produces no result.
- GAP: SS_n=1 for GAP_CYC cycles.
  - tx_slot advances to (tx_slot+1) mod NUM_CH. The first-frame flag is cleared after the first frame.
- One-shot sweep (cont=0): NUM_CH+1 frames. The final frame resends slot 0's address as a dummy and returns slot NUM_CH-1.
  - sweep_done pulses in the same cycle as vld[NUM_CH-1]. After GAP, go to IDLE with busy=0.
- Continuous (cont=1): frames run back to back, wrapping the slot index.
  - sweep_done pulses each time slot NUM_CH-1 is written. The first-frame flag is not re-set on wrap.
  - If cont falls mid-sweep, the current sweep completes through the write of slot NUM_CH-1, then the block returns to IDLE.
- NUM_CH=1: every frame addresses the same channel. One-shot = 2 frames.
- Frame length = 17*SCLK_DIV clk cycles of SS_n low. Frame period = 17*SCLK_DIV + GAP_CYC.
- results hold their last value between updates. vld and sweep_done are never high for more than 1 cycle.

Test Plan:
- NUM_CH=4, SCLK_DIV=4, GAP_CYC=2. The A2D model returns 12'h100+ch for the channel addressed in the previous frame. strt pulse, cont=0 -> exactly 5 SS_n low periods of 68 cycles each; results = {12'h103,12'h102,12'h101,12'h100}; vld pulses in order 0,1,2,3; sweep_done coincides with vld[3]; busy drops after the last GAP.
- MOSI check: CH_MAP slots = {5,7,0,2} -> captured frame address bits [13:11] sequence 5,7,0,2,5. Slot 0 result equals the model's ch5 value.
- Continuous: cont=1 for 3 sweeps, then cont=0 -> 13 frames total, sweep_done pulsed 3 times, then IDLE. A model value change between sweeps appears in the next sweep's results.
- strt asserted during SHIFT -> no extra frame, busy unchanged.
- rst_n low midway through SHIFT of frame 3 -> SS_n=1, SCLK=1, results=0 immediately. A following strt produces a clean 5-frame sweep.
- Model drives MISO upper 4 bits = 4'hF, data 12'hABC -> result 12'hABC. SCLK high/low phases measured at SCLK_DIV/2 cycles.
